// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the execute-stage add/subtract arbiter.
// rsp_t is the canonical response record for the default 32-bit, up-to-4-requester build.
package adder_arb_pkg;

   localparam logic [6:0] FUNCT7_SUB = 7'h20;

   localparam int RSP_ID_W = 2;
   localparam int RSP_Y_W  = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   typedef struct packed {
      logic [RSP_ID_W-1:0] id;
      logic [RSP_Y_W-1:0]  y;
      logic                c;
      logic                v;
      logic                n;
      logic                z;
   } rsp_t;

endpackage

// File: rtl/adder_arbiter_add_sub_core.sv
// Combinational WIDTH-bit add/subtract with carry/borrow, signed overflow, negative and zero flags.
module add_sub_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] y,
   output logic             c,
   output logic             v,
   output logic             n,
   output logic             z
);

   logic [WIDTH:0] full;

   always_comb begin
      full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      y    = full[WIDTH-1:0];
      // on subtract the top bit is the borrow (a < b unsigned)
      c    = full[WIDTH];
      if (sub)
         v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      else
         v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      n    = y[WIDTH-1];
      z    = (y == '0);
   end

endmodule

// File: rtl/adder_arbiter.sv
// Arbitrates NUM_REQ requesters onto one add/sub core and returns results via a one-entry slot.
// Define ADDER_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
//
// state | meaning
// EMPTY | response slot free, RSP_VALID=0
// FULL  | response slot holds a result, RSP_VALID=1
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [NUM_REQ-1:0]         REQ_VALID,
   output logic [NUM_REQ-1:0]         REQ_READY,
   input  logic [NUM_REQ*WIDTH-1:0]   REQ_A,
   input  logic [NUM_REQ*WIDTH-1:0]   REQ_B,
   input  logic [NUM_REQ-1:0]         REQ_SUB,
   output logic                       RSP_VALID,
   input  logic                       RSP_READY,
   output logic [$clog2(NUM_REQ)-1:0] RSP_ID,
   output logic [WIDTH-1:0]           RSP_Y,
   output logic                       RSP_C,
   output logic                       RSP_V,
   output logic                       RSP_N,
   output logic                       RSP_Z
);

   localparam int ID_W = $clog2(NUM_REQ);

   state_e          state;
   logic            can_accept;
   logic            xfer;
   logic [ID_W-1:0] grant_id;

   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic             sub_sel;
   logic [WIDTH-1:0] core_y;
   logic             core_c;
   logic             core_v;
   logic             core_n;
   logic             core_z;

   assign can_accept = (state == EMPTY) || RSP_READY;
   assign xfer       = RST_N && can_accept && (|REQ_VALID);

`ifdef ADDER_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] ptr;

   always_comb begin
      int   idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      grant_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && (j == idx) && REQ_VALID[j]) begin
               found    = 1'b1;
               grant_id = ID_W'(j);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N)
         ptr <= '0;
      else if (xfer)
         ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
   end
`else
   always_comb begin
      grant_id = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (REQ_VALID[j])
            grant_id = ID_W'(j);
      end
   end
`endif

   // grant depends only on valids, pointer and slot occupancy, never on operands
   always_comb begin
      REQ_READY = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (xfer && (grant_id == ID_W'(j)))
            REQ_READY[j] = 1'b1;
      end
   end

   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      sub_sel = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_id == ID_W'(j)) begin
            a_sel   = REQ_A[j*WIDTH +: WIDTH];
            b_sel   = REQ_B[j*WIDTH +: WIDTH];
            sub_sel = REQ_SUB[j];
         end
      end
   end

   add_sub_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a   (a_sel),
      .b   (b_sel),
      .sub (sub_sel),
      .y   (core_y),
      .c   (core_c),
      .v   (core_v),
      .n   (core_n),
      .z   (core_z)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= EMPTY;
         RSP_ID <= '0;
         RSP_Y  <= '0;
         RSP_C  <= 1'b0;
         RSP_V  <= 1'b0;
         RSP_N  <= 1'b0;
         RSP_Z  <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (xfer)
                  state <= FULL;
            end
            FULL: begin
               if (RSP_READY && !xfer)
                  state <= EMPTY;
            end
            default: state <= EMPTY;
         endcase
         if (xfer) begin
            RSP_ID <= grant_id;
            RSP_Y  <= core_y;
            RSP_C  <= core_c;
            RSP_V  <= core_v;
            RSP_N  <= core_n;
            RSP_Z  <= core_z;
         end
      end
   end

   assign RSP_VALID = (state == FULL);

endmodule
